// File: rtl/ahblite_slave_mux.sv
`default_nettype none
// ============================================================================
// Module : ahblite_slave_mux
// AHB-Lite data-phase response mux with an integrated two-cycle ERROR default slave.
// Rev    : 1.0
// ============================================================================
module ahblite_slave_mux #(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b1,
    parameter bit Port2_en = 1'b1,
    parameter bit Port3_en = 1'b1,
    parameter bit Port4_en = 1'b1,
    parameter bit Port5_en = 1'b1,
    parameter bit Port6_en = 1'b1,
    parameter bit Port7_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,

    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P5_HSEL,
    input  logic        P6_HSEL,
    input  logic        P7_HSEL,

    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P5_HREADYOUT,
    input  logic        P6_HREADYOUT,
    input  logic        P7_HREADYOUT,

    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic        P5_HRESP,
    input  logic        P6_HRESP,
    input  logic        P7_HRESP,

    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    input  logic [31:0] P5_HRDATA,
    input  logic [31:0] P6_HRDATA,
    input  logic [31:0] P7_HRDATA,

    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam logic [7:0] c_port_en = {Port7_en, Port6_en, Port5_en, Port4_en,
                                        Port3_en, Port2_en, Port1_en, Port0_en};

    logic [7:0]  w_hsel;
    logic [7:0]  w_en_sel;
    logic [7:0]  w_slv_ready;
    logic [7:0]  w_slv_resp;
    logic [31:0] w_slv_rdata [8];
    logic        w_active;
    logic        w_unmapped_active;
    logic        w_ds_ready;
    logic        w_ds_resp;
    logic        w_any_sel;
    logic [2:0]  w_idx;

    logic [7:0]  sel_q;
    logic [7:0]  sel_d;
    logic        dflt_q;
    logic        dflt_d;
    ds_state_t   state_q;
    ds_state_t   state_d;

    assign w_hsel      = {P7_HSEL, P6_HSEL, P5_HSEL, P4_HSEL,
                          P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign w_slv_ready = {P7_HREADYOUT, P6_HREADYOUT, P5_HREADYOUT, P4_HREADYOUT,
                          P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign w_slv_resp  = {P7_HRESP, P6_HRESP, P5_HRESP, P4_HRESP,
                          P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

    assign w_slv_rdata[0] = P0_HRDATA;
    assign w_slv_rdata[1] = P1_HRDATA;
    assign w_slv_rdata[2] = P2_HRDATA;
    assign w_slv_rdata[3] = P3_HRDATA;
    assign w_slv_rdata[4] = P4_HRDATA;
    assign w_slv_rdata[5] = P5_HRDATA;
    assign w_slv_rdata[6] = P6_HRDATA;
    assign w_slv_rdata[7] = P7_HRDATA;

    // Only NONSEQ/SEQ are real transfers; IDLE/BUSY to unmapped space get OKAY.
    assign w_active          = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign w_en_sel          = w_hsel & c_port_en;
    assign w_unmapped_active = (w_en_sel == 8'd0) && w_active;

    always_comb begin
        sel_d  = sel_q;
        dflt_d = dflt_q;
        if (HREADY) begin
            sel_d  = w_en_sel;
            dflt_d = w_unmapped_active;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q   <= 8'd0;
            dflt_q  <= 1'b0;
            state_q <= DS_IDLE;
        end else begin
            sel_q   <= sel_d;
            dflt_q  <= dflt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_ds_ready = 1'b1;
        w_ds_resp  = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (HREADY && w_unmapped_active) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                w_ds_ready = 1'b0;
                w_ds_resp  = dflt_q;
                state_d    = DS_ERR2;
            end
            DS_ERR2: begin
                w_ds_resp = dflt_q;
                // The ERR2 edge always completes, so a new error may chain directly.
                state_d   = (HREADY && w_unmapped_active) ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    always_comb begin
        w_any_sel = 1'b1;
        w_idx     = 3'd0;
        casez (sel_q)
            8'b???????1: w_idx = 3'd0;
            8'b??????10: w_idx = 3'd1;
            8'b?????100: w_idx = 3'd2;
            8'b????1000: w_idx = 3'd3;
            8'b???10000: w_idx = 3'd4;
            8'b??100000: w_idx = 3'd5;
            8'b?1000000: w_idx = 3'd6;
            8'b10000000: w_idx = 3'd7;
            default:     w_any_sel = 1'b0;
        endcase
    end

    always_comb begin
        HREADYOUT = w_ds_ready;
        HRESP     = w_ds_resp;
        HRDATA    = 32'd0;
        if (w_any_sel) begin
            HREADYOUT = w_slv_ready[w_idx];
            HRESP     = w_slv_resp[w_idx];
            HRDATA    = w_slv_rdata[w_idx];
        end
    end

endmodule
`default_nettype wire
